// File: rtl/sata_dbg_probe.sv
// sata_dbg_probe: registers SATA link Rx/Tx dwords and status, detects a
// selectable link primitive event, qualifies it with an armed trigger FSM
// that has a holdoff window, and packs a 128-bit word for the ILA TRIG0.
// Ports:
//   clk, rst_n                  link clock, async active-low reset
//   rx_data/rx_charisk          received dword and K-flags
//   tx_data/tx_charisk          transmitted dword and K-flags
//   link_up, phy_ready          link status
//   arm, disarm, trig_sel       trigger control and event select
//   trig0, trig_event, event_cnt  probe word, fire pulse, fire count
module sata_dbg_probe #(
    parameter int unsigned C_HOLDOFF = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  rx_data,
    input  logic [3:0]   rx_charisk,
    input  logic [31:0]  tx_data,
    input  logic [3:0]   tx_charisk,
    input  logic         link_up,
    input  logic         phy_ready,
    input  logic         arm,
    input  logic         disarm,
    input  logic [1:0]   trig_sel,
    output logic [127:0] trig0,
    output logic         trig_event,
    output logic [15:0]  event_cnt
);

    localparam logic [31:0] SOF  = 32'h3737B57C;
    localparam logic [31:0] EOF  = 32'hD5D5B57C;
    localparam logic [31:0] RERR = 32'h5656B57C;
    localparam logic [7:0]  HOLD_LOAD = 8'(C_HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRED = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // stage 1
    logic [31:0] rx_data_q, tx_data_q;
    logic [3:0]  rx_k_q, tx_k_q;
    logic        link_up_q, link_up_prev_q, phy_ready_q;
    logic        arm_q, disarm_q;
    logic [1:0]  sel_q;

    // control / stage 2
    state_t       state_q, state_d;
    logic [7:0]   hold_q, hold_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [31:0]  ts_q;
    logic [127:0] trig0_q, trig0_d;
    logic         ev_q;
    logic         fire;
    logic         raw_hit;
    logic         is_prim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q      <= '0;
            tx_data_q      <= '0;
            rx_k_q         <= '0;
            tx_k_q         <= '0;
            link_up_q      <= 1'b0;
            link_up_prev_q <= 1'b0;
            phy_ready_q    <= 1'b0;
            arm_q          <= 1'b0;
            disarm_q       <= 1'b0;
            sel_q          <= '0;
        end else begin
            rx_data_q      <= rx_data;
            tx_data_q      <= tx_data;
            rx_k_q         <= rx_charisk;
            tx_k_q         <= tx_charisk;
            link_up_q      <= link_up;
            link_up_prev_q <= link_up_q;
            phy_ready_q    <= phy_ready;
            arm_q          <= arm;
            disarm_q       <= disarm;
            sel_q          <= trig_sel;
        end
    end

    // primitives carry a single K28.3 in byte 0
    assign is_prim = (rx_k_q == 4'b0001);

    always_comb begin
        raw_hit = 1'b0;
        unique case (sel_q)
            2'd0: raw_hit = is_prim && (rx_data_q == SOF);
            2'd1: raw_hit = is_prim && (rx_data_q == EOF);
            2'd2: raw_hit = is_prim && (rx_data_q == RERR);
            2'd3: raw_hit = link_up_prev_q && !link_up_q;
        endcase
    end

    // holdoff is loaded on the fire edge and also counts during FIRED,
    // so the next fire can come C_HOLDOFF+1 cycles after the last one
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fire    = 1'b0;
        if (disarm_q) begin
            state_d = S_IDLE;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm_q) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (raw_hit) begin
                        state_d = S_FIRED;
                        hold_d  = HOLD_LOAD;
                        fire    = 1'b1;
                    end
                end
                S_FIRED: begin
                    state_d = S_HOLD;
                    hold_d  = (hold_q == 8'd0) ? 8'd0 : hold_q - 8'd1;
                end
                S_HOLD: begin
                    if (hold_q == 8'd0) state_d = S_ARMED;
                    else                hold_d  = hold_q - 8'd1;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (fire && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    assign trig0_d = {ts_q, cnt_d, 3'b000, state_d, fire,
                      phy_ready_q, link_up_q, tx_k_q, rx_k_q,
                      tx_data_q, rx_data_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            ts_q    <= '0;
            trig0_q <= '0;
            ev_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_q + 32'd1;
            trig0_q <= trig0_d;
            ev_q    <= fire;
        end
    end

    assign trig0      = trig0_q;
    assign trig_event = ev_q;
    assign event_cnt  = cnt_q;

endmodule
